alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  WIDTH  32  datapath width in bits.
  SHW  5  shift-amount width, log2(WIDTH).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on its rising edge.
  reset  in  1  synchronous, active-high reset.
  start  in  1  request to execute one operation; accepted only when busy=0.
  sel  in  4  operation code, same encoding the ALU control decoder produces.
  a  in  WIDTH  operand A (rs).
  b  in  WIDTH  operand B (rt or immediate); also the shift source.
  shamt  in  SHW  shift amount for sll, srl and sra.
  busy  out  1  high while an iterative shift is in progress.
  done  out  1  one-cycle pulse: result is valid.
  result  out  WIDTH  registered result, held until the next accepted operation.
  zero  out  1  registered flag, result==0, updated together with result.
  illegal  out  1  one-cycle pulse with done when sel is not a legal code.

Function
REQ-003 Legal sel codes SHALL be: 0 and; 1 or; 2 add; 6 sub; 7 slt; 11 sra; 12 nor; 13 xor; 14 sll; 15 srl.
REQ-004 Add and sub SHALL wrap modulo 2^WIDTH, with no overflow signalling.
REQ-005 slt SHALL compare a and b as signed values and return 1 or 0, zero-extended to WIDTH.
REQ-006 Shifts SHALL operate on b by shamt. srl and sll fill with 0; sra replicates b[WIDTH-1].
REQ-007 An illegal sel SHALL complete as a single-cycle op with result=0, zero=1 and illegal=1.
REQ-008 Operand and op-code capture:
  - start is accepted in cycle T iff start=1, busy=0 and reset=0.
  - a, b, sel and shamt SHALL be captured at the end of cycle T.
  - Inputs SHALL be ignored in every other cycle.
REQ-009 Non-shift op, or shift with shamt=0: result, zero and done SHALL be valid in cycle T+1, with busy=0.
REQ-010 Shift with shamt=n>0:
  - the block SHALL shift one bit per cycle;
  - busy=1 in cycles T+1..T+n;
  - done=1 with the final result in cycle T+n+1.
REQ-011 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-012 busy SHALL be 0 in a done cycle, so a start in that cycle is accepted (back-to-back issue).
REQ-013 result and zero SHALL NOT change during busy cycles; they update only in a done cycle.
REQ-014 FSM states SHALL be IDLE, SHIFT and FIN:
  - IDLE to FIN on an accepted non-shift or shamt=0 op.
  - IDLE to SHIFT on an accepted shift with shamt>0.
  - SHIFT to FIN when the remaining count reaches 0.
  - FIN to SHIFT or FIN on an accepted start, else FIN to IDLE.
  - done=1 exactly in FIN.

Reset
REQ-015 While reset=1, state SHALL go to IDLE and outputs SHALL be: busy=0, done=0, illegal=0, result=0, zero=1.
REQ-016 Reset asserted mid-shift SHALL abort the operation: no done pulse is issued, and result is not updated with partial data.
REQ-017 A start asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-018 A shared package alu_pkg SHALL hold:
  - the sel code constants (ALU_AND..ALU_SRL);
  - the FSM state encoding;
  - the default WIDTH.
REQ-019 The iterative shifter SHALL be one sub-module, alu_shifter, providing load, step and a remaining-count output.
REQ-020 Single-cycle ops SHALL be computed combinationally and registered in alu_exec_unit.

Verification
REQ-021 Add: start with sel=2, a=0xFFFFFFFF, b=1 -> cycle T+1: done=1, result=0, zero=1, busy never asserted.
REQ-022 slt: sel=7, a=0x80000000, b=1 -> result=1. sub: sel=6, a=5, b=7 -> result=0xFFFFFFFE.
REQ-023 sra: sel=11, b=0x80000000, shamt=4 -> busy=1 in T+1..T+4, done in T+5, result=0xF8000000.
REQ-024 Start with sel=14 while busy: extra start pulses are ignored; next start in the done cycle is accepted and its done appears at T'+1.
REQ-025 Reset and illegal code:
  - reset asserted in cycle T+2 of srl with shamt=10 -> no done, result=0, zero=1, busy=0 from the next cycle;
  - sel=3 -> illegal=1 and done=1 in T+1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: op codes, FSM encoding and default width.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_SRA = 4'd11;
   localparam logic [3:0] ALU_NOR = 4'd12;
   localparam logic [3:0] ALU_XOR = 4'd13;
   localparam logic [3:0] ALU_SLL = 4'd14;
   localparam logic [3:0] ALU_SRL = 4'd15;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StFin   = 2'd2
   } alu_state_e;

   typedef enum logic [1:0] {
      ShLeft       = 2'd0,
      ShRightLogic = 2'd1,
      ShRightArith = 2'd2
   } shift_kind_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter; o_next is the value after the next step so the
// caller can register the final result in the same edge that exhausts the count.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
   input  shift_kind_e      i_kind,
   input  logic [WIDTH-1:0] i_data,
   input  logic [SHW-1:0]   i_amt,
   output logic [WIDTH-1:0] o_next,
   output logic [SHW-1:0]   o_remaining
);

   logic [WIDTH-1:0] r_data;
   logic [SHW-1:0]   r_count;
   shift_kind_e      r_kind;
   logic [WIDTH-1:0] w_next;

   always_comb begin
      w_next = r_data;
      case (r_kind)
         ShLeft:       w_next = {r_data[WIDTH-2:0], 1'b0};
         ShRightLogic: w_next = {1'b0, r_data[WIDTH-1:1]};
         ShRightArith: w_next = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
         default:      w_next = r_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= '0;
         r_count <= '0;
         r_kind  <= ShLeft;
      end else if (i_load) begin
         r_data  <= i_data;
         r_count <= i_amt;
         r_kind  <= i_kind;
      end else if (i_step && (r_count != '0)) begin
         r_data  <= w_next;
         r_count <= r_count - SHW'(1);
      end
   end

   assign o_next      = w_next;
   assign o_remaining = r_count;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops, iterative shifts through
// alu_shifter, registered result/zero and a done pulse from the FIN state.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   alu_state_e       r_state;
   alu_state_e       w_state_next;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_result_next;
   logic             r_zero;
   logic             w_zero_next;
   logic             r_illegal;
   logic             w_illegal_next;

   logic             w_accept;
   logic             w_iter;
   logic             w_legal;
   logic [WIDTH-1:0] w_alu_res;
   shift_kind_e      w_kind;
   logic             w_load;
   logic             w_step;
   logic [WIDTH-1:0] w_sh_next;
   logic [SHW-1:0]   w_sh_remaining;

   assign busy     = (r_state == StShift);
   assign done     = (r_state == StFin);
   assign result   = r_result;
   assign zero     = r_zero;
   assign illegal  = r_illegal;

   assign w_accept = start && !busy && !reset;
   // A zero-amount shift is just b and completes like any single-cycle op.
   assign w_iter   = is_shift_op(sel) && (shamt != '0);

   always_comb begin
      w_alu_res = '0;
      w_legal   = 1'b1;
      case (sel)
         ALU_AND: w_alu_res = a & b;
         ALU_OR:  w_alu_res = a | b;
         ALU_ADD: w_alu_res = a + b;
         ALU_SUB: w_alu_res = a - b;
         ALU_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_NOR: w_alu_res = ~(a | b);
         ALU_XOR: w_alu_res = a ^ b;
         ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = b;
         default: w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_kind = ShRightLogic;
      if (sel == ALU_SLL) begin
         w_kind = ShLeft;
      end else if (sel == ALU_SRA) begin
         w_kind = ShRightArith;
      end
   end

   alu_shifter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_shifter (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_step      (w_step),
      .i_kind      (w_kind),
      .i_data      (b),
      .i_amt       (shamt),
      .o_next      (w_sh_next),
      .o_remaining (w_sh_remaining)
   );

   always_comb begin
      w_state_next   = r_state;
      w_result_next  = r_result;
      w_zero_next    = r_zero;
      w_illegal_next = 1'b0;
      w_load         = 1'b0;
      w_step         = 1'b0;
      case (r_state)
         StIdle, StFin: begin
            if (w_accept) begin
               if (w_iter) begin
                  w_state_next = StShift;
                  w_load       = 1'b1;
               end else begin
                  w_state_next   = StFin;
                  w_result_next  = w_alu_res;
                  w_zero_next    = (w_alu_res == '0);
                  w_illegal_next = !w_legal;
               end
            end else begin
               w_state_next = StIdle;
            end
         end
         StShift: begin
            w_step = 1'b1;
            // Last step: capture the post-step value so result is valid in FIN.
            if (w_sh_remaining == SHW'(1)) begin
               w_state_next  = StFin;
               w_result_next = w_sh_next;
               w_zero_next   = (w_sh_next == '0);
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= StIdle;
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_result  <= w_result_next;
         r_zero    <= w_zero_next;
         r_illegal <= w_illegal_next;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against a behavioural ALU model.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  sel;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_res = 32'h0;

   alu_exec_unit #(
      .WIDTH (32),
      .SHW   (5)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .sel     (sel),
      .a       (a),
      .b       (b),
      .shamt   (shamt),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .zero    (zero),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Result, illegal flag and number of busy cycles for one operation.
   function automatic void ref_model(input logic [3:0] s, input logic [31:0] x,
                                     input logic [31:0] y, input logic [4:0] sh,
                                     output logic [31:0] r, output logic ill, output int n);
      ill = 1'b0;
      n   = 0;
      r   = 32'h0;
      case (s)
         4'd0:  r = x & y;
         4'd1:  r = x | y;
         4'd2:  r = x + y;
         4'd6:  r = x - y;
         4'd7:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd12: r = ~(x | y);
         4'd13: r = x ^ y;
         4'd11: begin r = $unsigned($signed(y) >>> sh); n = int'(sh); end
         4'd14: begin r = y << sh; n = int'(sh); end
         4'd15: begin r = y >> sh; n = int'(sh); end
         default: ill = 1'b1;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic issue(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] sh);
      logic [31:0] er;
      logic        ei;
      int          n;
      ref_model(s, x, y, sh, er, ei, n);
      start = 1'b1;
      sel   = s;
      a     = x;
      b     = y;
      shamt = sh;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         start = 1'($urandom_range(0, 1));
         sel   = 4'($urandom);
         a     = $urandom;
         b     = $urandom;
         shamt = 5'($urandom);
         check_eq("busy_high", busy, 1);
         check_eq("busy_no_done", done, 0);
         check_eq("busy_hold_result", result, last_res);
         check_eq("busy_hold_zero", zero, last_res == 32'h0);
         @(negedge clk);
      end
      check_eq("done_pulse", done, 1);
      check_eq("done_busy_low", busy, 0);
      check_eq("done_result", result, er);
      check_eq("done_zero", zero, er == 32'h0);
      check_eq("done_illegal", illegal, ei);
      last_res = er;
      start    = 1'b0;
   endtask

   task automatic idle_cycle();
      start = 1'b0;
      sel   = 4'($urandom);
      a     = $urandom;
      b     = $urandom;
      @(negedge clk);
      check_eq("idle_done", done, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_illegal", illegal, 0);
      check_eq("idle_result", result, last_res);
   endtask

   logic [3:0] legal_ops [10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

   initial begin
      reset = 1'b1;
      start = 1'b1;
      sel   = 4'd2;
      a     = 32'h1;
      b     = 32'h1;
      shamt = 5'd0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_illegal", illegal, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_zero", zero, 1);
      reset = 1'b0;
      start = 1'b0;
      idle_cycle();

      issue(4'd2, 32'hFFFF_FFFF, 32'h1, 5'd3);
      check_eq("add_wrap_const", result, 32'h0);
      issue(4'd7, 32'h8000_0000, 32'h1, 5'd0);
      check_eq("slt_const", result, 32'h1);
      issue(4'd6, 32'd5, 32'd7, 5'd0);
      check_eq("sub_const", result, 32'hFFFF_FFFE);
      idle_cycle();
      issue(4'd11, 32'h0, 32'h8000_0000, 5'd4);
      check_eq("sra_const", result, 32'hF800_0000);
      // Back-to-back: next start in the done cycle.
      issue(4'd14, 32'h0, 32'h0000_0003, 5'd6);
      issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd9);
      issue(4'd3, 32'h1234, 32'h5678, 5'd0);
      check_eq("illegal_const", result, 32'h0);
      idle_cycle();

      // Reset in cycle T+2 of a 10-step srl, with a start in the reset cycle.
      start = 1'b1;
      sel   = 4'd15;
      a     = 32'h0;
      b     = 32'hDEAD_BEEF;
      shamt = 5'd10;
      @(negedge clk);
      start = 1'b0;
      check_eq("srl_busy_t1", busy, 1);
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      sel   = 4'd2;
      a     = 32'h5;
      b     = 32'h6;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_result", result, 0);
      check_eq("abort_zero", zero, 1);
      last_res = 32'h0;
      idle_cycle();

      for (int k = 0; k < 200; k++) begin
         logic [3:0] s;
         logic [4:0] sh;
         s  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 9)];
         sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         issue(s, $urandom, $urandom, sh);
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
